// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
// -----------------
// Target end of the core's load/store memory interface. Takes one request at
// a time (read, or byte-masked write), waits LATENCY cycles, then presents a
// response and holds it until the requester takes it. Storage is an internal
// word-organized array of 2**DEPTH_LOG2 32-bit words mapped at BASE_ADDR.
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-low reset
//   i_req_valid  request valid
//   o_req_ready  responder can accept a request (high only in IDLE)
//   i_req_wen    1 = write, 0 = read
//   i_req_addr   byte address
//   i_req_wdata  write data, right-justified (byte 0 in bits 7:0)
//   i_req_wmask  size mask: 8'h01 byte, 8'h03 half, 8'h0F word (writes only)
//   o_rsp_valid  response valid (high only in RESP)
//   i_rsp_ready  requester accepts the response
//   o_rsp_rdata  read data: aligned word containing the address, unshifted
//   o_rsp_err    access fault for this response
//   o_dbg_state  current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A request is taken only while o_req_ready is high; once in RESP,
// o_rsp_valid, o_rsp_rdata and o_rsp_err stay constant until the edge on
// which i_rsp_ready is high. The request bus is only looked at in IDLE.

module lsu_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [7:0]            i_req_wmask,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [1:0]            o_dbg_state
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic [3:0] cnt;

  // Latched request; the live request bus is ignored outside IDLE.
  logic                  lat_wen;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [7:0]            lat_wmask;

  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ------------------------------------------------------------------
  // Address decode and access checks, all from the latched request.
  // ------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] offset;
  logic                  above_base;
  logic                  below_top;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic                  mask_err;
  logic                  acc_err;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  commit;
  logic                  write_en;

  assign offset     = lat_addr - BASE_ADDR;
  assign above_base = (lat_addr >= BASE_ADDR);
  // Anything at or above 4 * DEPTH bytes past the base has a nonzero bit
  // above the byte-offset field.
  assign below_top  = ((offset >> (DEPTH_LOG2 + 2)) == '0);
  assign in_range   = above_base && below_top;
  assign word_idx   = offset[DEPTH_LOG2+1:2];
  assign lane       = lat_addr[1:0];

  // Reads never fault on size or alignment; writes must use a legal mask
  // and be naturally aligned for that size.
  always_comb begin
    mask_err = 1'b0;
    if (lat_wen) begin
      case (lat_wmask)
        8'h01:   mask_err = 1'b0;
        8'h03:   mask_err = lane[0];
        8'h0F:   mask_err = (lane != 2'd0);
        default: mask_err = 1'b1;
      endcase
    end
  end

  assign acc_err  = !in_range || mask_err;

  // Legal accesses never shift enables past lane 3, so truncation is safe.
  assign byte_en  = lat_wmask[3:0] << lane;
  assign wdata_sh = lat_wdata << {lane, 3'b000};

  assign rd_word  = mem[word_idx];

  // The access happens on exactly one edge: the BUSY-to-RESP transition.
  assign commit   = (state == BUSY) && (cnt == 4'd0);
  assign write_en = commit && lat_wen && !acc_err;

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= 8'h00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            lat_wen   <= i_req_wen;
            lat_addr  <= i_req_addr;
            lat_wdata <= i_req_wdata;
            lat_wmask <= i_req_wmask;
            cnt       <= CNT_INIT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            rsp_err   <= acc_err;
            // Writes and faulted accesses return zero data.
            rsp_rdata <= (lat_wen || acc_err) ? '0 : rd_word;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset. A reset during BUSY forces IDLE before the commit
  // edge, so an aborted write never reaches the array.
  always_ff @(posedge i_clk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Testbench for lsu_mem_responder. A byte-addressed reference model predicts
// every response from the address map and size rules; a compare process
// checks ready/valid/data against it on every falling edge, and directed
// transactions pin the model with hand-computed literal values.

module tb_lsu_mem_responder;

  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          BYTES = 4096;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_wen = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic [7:0]  i_req_wmask = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_dbg_state;

  always #5 i_clk = ~i_clk;

  lsu_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h80000000),
    .LATENCY    (LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_wen   (i_req_wen),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_wmask (i_req_wmask),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] exp_q[$];          // {err, rdata} per accepted request
  logic [7:0]  mem_m [int];       // byte offset -> byte value
  logic        pend = 1'b0;       // a transaction is outstanding
  int          acc  = 0;          // cycle number of its accept edge
  logic        pw_en = 1'b0;      // write waiting to land
  int          pw_base = 0;
  int          pw_n = 0;
  logic [7:0]  pw_bytes [4];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] mbyte(input int a);
    return mem_m.exists(a) ? mem_m[a] : 8'h00;
  endfunction

  // ---------------- reference model ----------------
  // Works in bytes: an access is legal if inside the 4 KiB window and (for
  // writes) a naturally aligned byte/half/word. The write lands LAT edges
  // after the accept unless reset intervenes.
  always @(posedge i_clk) begin
    logic [31:0] a, off, rd;
    int          lane, sz;
    bit          ok;
    if (!i_rst) begin
      pend  = 1'b0;
      pw_en = 1'b0;
      exp_q.delete();
    end else if (pend && cyc >= acc + LAT && i_rsp_ready) begin
      pend = 1'b0;
      void'(exp_q.pop_front());
    end else if (!pend && i_req_valid) begin
      a    = i_req_addr;
      off  = a - BASE;
      lane = int'(a[1:0]);
      ok   = (a >= BASE) && (off < BYTES);
      sz   = 0;
      if (i_req_wen) begin
        case (i_req_wmask)
          8'h01:   sz = 1;
          8'h03:   sz = (lane % 2 == 0) ? 2 : 0;
          8'h0F:   sz = (lane == 0) ? 4 : 0;
          default: sz = 0;
        endcase
        if (sz == 0) ok = 1'b0;
      end
      rd    = '0;
      pw_en = 1'b0;
      if (ok && !i_req_wen) begin
        for (int b = 0; b < 4; b++) rd[8*b +: 8] = mbyte(int'(off) - lane + b);
      end
      if (ok && i_req_wen) begin
        pw_en   = 1'b1;
        pw_base = int'(off);
        pw_n    = sz;
        for (int b = 0; b < 4; b++) pw_bytes[b] = i_req_wdata[8*b +: 8];
      end
      exp_q.push_back({~ok, rd});
      pend = 1'b1;
      acc  = cyc + 1;
    end
    cyc++;
    if (i_rst && pend && pw_en && cyc == acc + LAT) begin
      for (int b = 0; b < pw_n; b++) mem_m[pw_base + b] = pw_bytes[b];
      pw_en = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    logic ev;
    if (i_rst) begin
      ev = pend && (cyc >= acc + LAT);
      check("req_ready", 33'(o_req_ready), 33'(!pend));
      check("rsp_valid", 33'(o_rsp_valid), 33'(ev));
      if (ev && exp_q.size() > 0) check("rsp_data", {o_rsp_err, o_rsp_rdata}, exp_q[0]);
    end
  end

  // ---------------- driver ----------------
  // Called on a falling edge; returns on the falling edge after the response
  // handshake, so a following call presents its request immediately.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] mask, input int hold,
                        output logic [32:0] rsp, output int lat, output int acc_c, output int hs_c);
    int g;
    rsp = '0; lat = -1; acc_c = -1; hs_c = -1;
    i_req_valid = 1'b1;
    i_req_wen   = wen;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_wmask = mask;
    g = 0;
    while (!o_req_ready && g < 50) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 50) begin
      fail_now("accept_wait");
      i_req_valid = 1'b0;
      return;
    end
    @(negedge i_clk);
    acc_c = cyc;
    // Garbage on the request bus must not disturb the latched transaction.
    i_req_valid = 1'b0;
    i_req_wen   = 1'($urandom_range(0, 1));
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    i_req_wmask = 8'($urandom_range(0, 255));
    lat = 0;
    while (!o_rsp_valid && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_rsp_valid) begin
      fail_now("rsp_wait");
      return;
    end
    rsp = {o_rsp_err, o_rsp_rdata};
    repeat (hold) @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    hs_c = cyc;
    i_rsp_ready = 1'b0;
  endtask

  task automatic txn(input string name, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] mask, input logic [32:0] exp);
    logic [32:0] rsp;
    int          lat, ac, hc;
    do_req(wen, addr, wdata, mask, 0, rsp, lat, ac, hc);
    check(name, rsp, exp);
    check({name, "_latency"}, 33'(lat), 33'(LAT));
  endtask

  localparam logic [32:0] ERR = {1'b1, 32'h0};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [32:0] rsp;
    int          lat, ac1, hc1, ac2, hc2;

    // Reset values while held in reset.
    repeat (3) @(negedge i_clk);
    check("reset_req_ready", 33'(o_req_ready), 33'(1));
    check("reset_rsp_valid", 33'(o_rsp_valid), 33'(0));
    check("reset_rsp_rdata", 33'(o_rsp_rdata), 33'(0));
    check("reset_rsp_err",   33'(o_rsp_err),   33'(0));
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    check("post_reset_req_ready", 33'(o_req_ready), 33'(1));

    // Word, byte and half writes with readback.
    txn("w_word",      1'b1, 32'h80000010, 32'hDEADBEEF, 8'h0F, 33'h0);
    txn("r_word",      1'b0, 32'h80000010, 32'h0,        8'h00, {1'b0, 32'hDEADBEEF});
    txn("w_byte",      1'b1, 32'h80000012, 32'h000000AA, 8'h01, 33'h0);
    txn("r_byte",      1'b0, 32'h80000010, 32'h0,        8'h00, {1'b0, 32'hDEAABEEF});
    txn("w_half",      1'b1, 32'h80000012, 32'h00001234, 8'h03, 33'h0);
    txn("r_half",      1'b0, 32'h80000010, 32'h0,        8'h00, {1'b0, 32'h1234BEEF});

    // Faults leave storage alone.
    txn("w_mis_half",  1'b1, 32'h80000011, 32'h0000FFFF, 8'h03, ERR);
    txn("r_oor_low",   1'b0, 32'h7FFFFFFC, 32'h0,        8'h00, ERR);
    txn("w_mis_word",  1'b1, 32'h80000012, 32'hFFFFFFFF, 8'h0F, ERR);
    txn("w_bad_mask",  1'b1, 32'h80000010, 32'hFFFFFFFF, 8'h07, ERR);
    txn("r_unchanged", 1'b0, 32'h80000010, 32'h0,        8'h00, {1'b0, 32'h1234BEEF});
    txn("r_unaligned", 1'b0, 32'h80000013, 32'h0,        8'h0F, {1'b0, 32'h1234BEEF});

    // Top of the window and just past it.
    txn("w_top",       1'b1, 32'h80000FFC, 32'hCAFEF00D, 8'h0F, 33'h0);
    txn("w_top_byte3", 1'b1, 32'h80000FFF, 32'h00000011, 8'h01, 33'h0);
    txn("r_top",       1'b0, 32'h80000FFC, 32'h0,        8'h00, {1'b0, 32'h11FEF00D});
    txn("r_past_top",  1'b0, 32'h80001000, 32'h0,        8'h00, ERR);
    txn("w_past_top",  1'b1, 32'h80001000, 32'h12345678, 8'h0F, ERR);

    // Backpressure, then an immediate follow-on request.
    do_req(1'b0, 32'h80000010, 32'h0, 8'h00, 3, rsp, lat, ac1, hc1);
    check("bp_read", rsp, {1'b0, 32'h1234BEEF});
    check("bp_latency", 33'(lat), 33'(LAT));
    check("bp_hold_cycles", 33'(hc1 - ac1), 33'(LAT + 3 + 1));
    do_req(1'b1, 32'h80000020, 32'h00000000, 8'h0F, 0, rsp, lat, ac2, hc2);
    check("bp_next_accept", 33'(ac2 - hc1), 33'(1));
    check("w_zero_0x20", rsp, 33'h0);

    // Reset in the middle of a write: no response, no commit.
    i_req_valid = 1'b1;
    i_req_wen   = 1'b1;
    i_req_addr  = 32'h80000020;
    i_req_wdata = 32'h55555555;
    i_req_wmask = 8'h0F;
    @(negedge i_clk);
    check("rst_busy_state_ready", 33'(o_req_ready), 33'(0));
    i_req_valid = 1'b0;
    #2 i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("rst_busy_no_valid", 33'(o_rsp_valid), 33'(0));
      check("rst_busy_ready",    33'(o_req_ready), 33'(1));
    end
    #2 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    txn("r_after_abort", 1'b0, 32'h80000020, 32'h0, 8'h00, {1'b0, 32'h00000000});
    txn("r_after_abort_keep", 1'b0, 32'h80000010, 32'h0, 8'h00, {1'b0, 32'h1234BEEF});

    repeat (2) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
